// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receiver with configurable width, parity, stop bits and break detect
module uart_rx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESC_W-1:0]    Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  brk_det,
  output logic                  busy
);
  localparam int BW = $clog2(DATA_WIDTH + 5);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;
  state_t state;
  logic [PRESC_W-1:0] p_l, edge_cnt, half, p_new;
  logic [BW-1:0] bit_cnt, last_bc;
  logic [DATA_WIDTH-1:0] sr;
  logic [1:0] smp;
  logic par_en_l, par_typ_l, stop2_l, bit_v, par_bit, perr, serr;
  logic wrap, res, maj, start, last_stop, active;
  always_comb begin
    half = p_l >> 1;
    wrap = edge_cnt == p_l - PRESC_W'(1);
    res = edge_cnt == half + PRESC_W'(1);
    maj = (smp[0] & smp[1]) | (smp[0] & RX_IN) | (smp[1] & RX_IN);
    p_new = Prescale < PRESC_W'(8) ? PRESC_W'(8) : Prescale;
    last_bc = BW'(DATA_WIDTH) + BW'(par_en_l) + (stop2_l ? BW'(2) : BW'(1));
    // final stop leaves one edge early so DONE lands on the bit's last edge
    last_stop = bit_cnt == last_bc && edge_cnt == p_l - PRESC_W'(2);
    start = (state == IDLE || state == DONE) && !RX_IN;
    active = state == START || state == DATA || state == PARITY || state == STOP;
  end
  assign busy = state != IDLE;
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      p_l <= '0;
      edge_cnt <= '0;
      bit_cnt <= '0;
      sr <= '0;
      smp <= '0;
      par_en_l <= 1'b0;
      par_typ_l <= 1'b0;
      stop2_l <= 1'b0;
      bit_v <= 1'b0;
      par_bit <= 1'b0;
      perr <= 1'b0;
      serr <= 1'b0;
      P_DATA <= '0;
      data_valid <= 1'b0;
      par_err <= 1'b0;
      stp_err <= 1'b0;
      brk_det <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err <= 1'b0;
      stp_err <= 1'b0;
      brk_det <= 1'b0;
      if (active) begin
        edge_cnt <= wrap ? '0 : edge_cnt + PRESC_W'(1);
        if (wrap) bit_cnt <= bit_cnt + BW'(1);
        if (edge_cnt == half - PRESC_W'(1)) smp[0] <= RX_IN;
        if (edge_cnt == half) smp[1] <= RX_IN;
      end
      if (start) begin
        state <= START;
        p_l <= p_new;
        par_en_l <= PAR_EN;
        par_typ_l <= PAR_TYP;
        stop2_l <= STOP2;
        edge_cnt <= PRESC_W'(1);
        bit_cnt <= '0;
        perr <= 1'b0;
        serr <= 1'b0;
        par_bit <= 1'b0;
      end else
        case (state)
          START: begin
            if (res) bit_v <= maj;
            if (wrap) state <= bit_v ? IDLE : DATA;
          end
          DATA: begin
            if (res) sr <= {maj, sr[DATA_WIDTH-1:1]};
            if (wrap && bit_cnt == BW'(DATA_WIDTH)) state <= par_en_l ? PARITY : STOP;
          end
          PARITY: begin
            if (res) begin
              par_bit <= maj;
              perr <= maj != (^sr ^ par_typ_l);
            end
            if (wrap) state <= STOP;
          end
          STOP: begin
            if (res && !maj) serr <= 1'b1;
            if (last_stop) begin
              state <= DONE;
              P_DATA <= sr;
              data_valid <= !(perr | serr);
              par_err <= perr;
              stp_err <= serr;
              brk_det <= serr & ~|sr & (~par_bit | ~par_en_l);
            end
          end
          DONE: state <= IDLE;
          default: ;
        endcase
    end
endmodule
